c1_bias_loader: RTL and testbench

Upstream parameter-load stage for the conv1 bias buffer. Accepts bias words from the parameter stream (DMA/host side) through a valid/ready handshake. Re-emits them to the bias buffer as exactly NW contiguous-or-throttled `c1_bias_en` beats, followed by a guaranteed idle cycle so the buffer's write counter wraps. Reports load completion to the layer controller.

---
 rtl/c1_pkg.sv | 14 +
 rtl/c1_bias_loader.sv | 91 +++++++++
 tb/tb_c1_bias_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1_pkg.sv
// Shared conv1 definitions: loader state encoding and the layer dimensions
// used by the bias loader, the bias buffer and the conv1 datapath.
package c1_pkg;

    localparam int C1_NW      = 6;
    localparam int C1_BIAS_WD = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } c1_ld_state_t;

endpackage

// File: rtl/c1_bias_loader.sv
// conv1 bias loader: takes NW words from the parameter stream and replays them
// as one-cycle write strobes into the bias buffer, then leaves one strobe-free
// cycle so the buffer write pointer wraps before the next load can start.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for i_start; s_ready low, stray s_valid flags overrun
// LOAD  | s_ready high, every handshake becomes a c1_bias_en beat
// FLUSH | one cycle, NW-th beat on the output, no new words accepted
module c1_bias_loader
    import c1_pkg::*;
#(
    parameter int WD = C1_BIAS_WD,
    parameter int NW = C1_NW
) (
    input  logic          i_sclk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [WD-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [WD-1:0] c1_bias_data,
    output logic          c1_bias_en,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_loaded,
    output logic          o_overrun
);

    localparam int CW = $clog2(NW + 1);

    c1_ld_state_t  state;
    logic [CW-1:0] cnt;

    // FSM with registered outputs; s_ready mirrors the LOAD state so it never
    // depends combinationally on s_valid.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            s_ready      <= 1'b0;
            c1_bias_data <= '0;
            c1_bias_en   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_loaded     <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            c1_bias_en <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        s_ready   <= 1'b1;
                        o_busy    <= 1'b1;
                        o_loaded  <= 1'b0;
                        o_overrun <= 1'b0;
                    end else if (s_valid && !s_ready) begin
                        o_overrun <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        c1_bias_data <= s_data;
                        c1_bias_en   <= 1'b1;
                        cnt          <= cnt + 1'b1;
                        if (cnt == CW'(NW - 1)) begin
                            state   <= FLUSH;
                            s_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b1;
                    o_loaded <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    s_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_bias_loader.sv
// Bench for c1_bias_loader: directed loads, scoreboard of expected words,
// and a bias-buffer model fed from the write strobes.
module tb_c1_bias_loader;

    localparam int WD = 8;
    localparam int NW = 6;

    logic          i_sclk  = 1'b0;
    logic          i_rst   = 1'b1;
    logic          i_start = 1'b0;
    logic [WD-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [WD-1:0] c1_bias_data;
    logic          c1_bias_en;
    logic          o_busy;
    logic          o_done;
    logic          o_loaded;
    logic          o_overrun;

    c1_bias_loader #(.WD(WD), .NW(NW)) dut (
        .i_sclk       (i_sclk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .c1_bias_data (c1_bias_data),
        .c1_bias_en   (c1_bias_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_loaded     (o_loaded),
        .o_overrun    (o_overrun)
    );

    always #5 i_sclk = ~i_sclk;

    int cyc = 0;
    always @(posedge i_sclk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    logic [WD-1:0] exp_q[$];
    int            en_q[$];
    int            done_q[$];
    logic [WD-1:0] bufm[NW];
    int            ptr = 0;
    logic          prev_rst = 1'b1;
    logic [WD-1:0] prev_data = '0;
    logic [WD-1:0] exp_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and keeps the buffer model.
    always @(negedge i_sclk) begin
        if (c1_bias_en) begin
            en_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_en actual=%0h required=no_strobe", c1_bias_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk("en_data", {24'd0, c1_bias_data}, {24'd0, exp_w});
            end
        end else if (!prev_rst) begin
            chk("data_held", {24'd0, c1_bias_data}, {24'd0, prev_data});
        end
        if (o_done) begin
            done_q.push_back(cyc);
            chk("done_en_low", {31'd0, c1_bias_en}, 32'd0);
            chk("done_loaded", {31'd0, o_loaded}, 32'd1);
        end
        if (i_rst) begin
            ptr = 0;
            for (int i = 0; i < NW; i++) bufm[i] = '0;
        end else if (c1_bias_en) begin
            bufm[ptr] = c1_bias_data;
            ptr = (ptr == NW - 1) ? 0 : ptr + 1;
        end
        prev_rst  = i_rst;
        prev_data = c1_bias_data;
    end

    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    task automatic start_load(output int t0);
        i_start = 1'b1;
        t0 = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [WD-1:0] d);
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_sclk);
            if (s_ready) begin
                exp_q.push_back(d);
                tick();
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL send_timeout actual=no_ready required=ready word=%0h", d);
    endtask

    task automatic wait_idle(input int ndone);
        for (int i = 0; i < 30; i++) begin
            if (!o_busy && done_q.size() >= ndone) return;
            tick();
        end
        checks++;
        fails++;
        $display("FAIL idle_timeout actual=%0d required=%0d", done_q.size(), ndone);
    endtask

    task automatic chk_en_seq(input int off, input int t0, input int gap_after, input int gap);
        int e;
        chk("en_count", en_q.size(), off + NW);
        if (en_q.size() >= off + NW) begin
            for (int k = 0; k < NW; k++) begin
                e = t0 + 2 + k + ((k >= gap_after) ? gap : 0);
                chk("en_cycle", en_q[off + k], e);
            end
        end
    endtask

    task automatic chk_buf(input logic [WD-1:0] first);
        for (int k = 0; k < NW; k++)
            chk("buf_word", {24'd0, bufm[k]}, {24'd0, first + WD'(k)});
    endtask

    task automatic clear_logs();
        en_q.delete();
        done_q.delete();
    endtask

    int t0, t1, t2;

    initial begin
        repeat (3) tick();
        chk("rst_en",      {31'd0, c1_bias_en}, 32'd0);
        chk("rst_data",    {24'd0, c1_bias_data}, 32'd0);
        chk("rst_ready",   {31'd0, s_ready}, 32'd0);
        chk("rst_busy",    {31'd0, o_busy}, 32'd0);
        chk("rst_done",    {31'd0, o_done}, 32'd0);
        chk("rst_loaded",  {31'd0, o_loaded}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        i_rst = 1'b0;
        tick();

        // full-rate load 0x11..0x16
        clear_logs();
        s_valid = 1'b1;
        s_data  = 8'h11;
        start_load(t0);
        chk("load_ready", {31'd0, s_ready}, 32'd1);
        for (int k = 0; k < NW; k++) send(8'h11 + 8'(k));
        s_valid = 1'b0;
        chk("flush_ready", {31'd0, s_ready}, 32'd0);
        chk("flush_busy", {31'd0, o_busy}, 32'd1);
        wait_idle(1);
        chk_en_seq(0, t0, NW, 0);
        chk("done_cnt", done_q.size(), 1);
        if (done_q.size() > 0) chk("done_cycle", done_q[0], t0 + NW + 2);
        chk("loaded_after", {31'd0, o_loaded}, 32'd1);
        chk("overrun_fr", {31'd0, o_overrun}, 32'd0);
        chk_buf(8'h11);
        tick();

        // throttled load: 3 idle cycles between words 2 and 3
        clear_logs();
        start_load(t0);
        chk("reload_clears_loaded", {31'd0, o_loaded}, 32'd0);
        send(8'h21);
        send(8'h22);
        s_valid = 1'b0;
        repeat (3) tick();
        for (int k = 2; k < NW; k++) send(8'h21 + 8'(k));
        s_valid = 1'b0;
        wait_idle(1);
        chk_en_seq(0, t0, 2, 3);
        if (done_q.size() > 0) chk("thr_done_cycle", done_q[0], t0 + NW + 5);
        chk_buf(8'h21);
        tick();

        // i_start mid-LOAD and in FLUSH is ignored
        clear_logs();
        start_load(t0);
        send(8'h31);
        send(8'h32);
        i_start = 1'b1;
        send(8'h33);
        i_start = 1'b0;
        for (int k = 3; k < NW; k++) send(8'h31 + 8'(k));
        s_valid = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        chk("ign_busy", {31'd0, o_busy}, 32'd0);
        wait_idle(1);
        repeat (3) tick();
        chk_en_seq(0, t0, NW, 0);
        chk("ign_done_cnt", done_q.size(), 1);
        chk_buf(8'h31);

        // i_start on the o_done cycle re-enters LOAD immediately
        clear_logs();
        start_load(t1);
        for (int k = 0; k < NW; k++) send(8'h41 + 8'(k));
        s_valid = 1'b0;
        tick();
        chk("b2b_done_now", {31'd0, o_done}, 32'd1);
        start_load(t2);
        chk("b2b_interval", t2 - t1, NW + 2);
        chk("b2b_busy", {31'd0, o_busy}, 32'd1);
        chk("b2b_ready", {31'd0, s_ready}, 32'd1);
        chk("b2b_loaded_clr", {31'd0, o_loaded}, 32'd0);
        for (int k = 0; k < NW; k++) send(8'h51 + 8'(k));
        s_valid = 1'b0;
        wait_idle(2);
        chk("b2b_en_count", en_q.size(), 2 * NW);
        if (en_q.size() >= 2 * NW) begin
            chk("b2b_en_first1", en_q[0], t1 + 2);
            chk("b2b_en_first2", en_q[NW], t2 + 2);
            chk("b2b_en_last2", en_q[2 * NW - 1], t2 + NW + 1);
        end
        chk("b2b_done_cnt", done_q.size(), 2);
        if (done_q.size() >= 2) begin
            chk("b2b_done1", done_q[0], t1 + NW + 2);
            chk("b2b_done2", done_q[1], t2 + NW + 2);
        end
        chk_buf(8'h51);
        tick();

        // s_valid while idle sets overrun; accepted start clears it
        clear_logs();
        s_data  = 8'h77;
        s_valid = 1'b1;
        repeat (2) tick();
        chk("ovr_set", {31'd0, o_overrun}, 32'd1);
        chk("ovr_ready", {31'd0, s_ready}, 32'd0);
        chk("ovr_no_en", en_q.size(), 0);
        start_load(t0);
        chk("ovr_cleared", {31'd0, o_overrun}, 32'd0);
        for (int k = 0; k < NW; k++) send(8'h61 + 8'(k));
        s_valid = 1'b0;
        wait_idle(1);
        chk_en_seq(0, t0, NW, 0);
        chk("ovr_stays_clear", {31'd0, o_overrun}, 32'd0);
        chk_buf(8'h61);
        tick();

        // reset after 3 of 6 words, then a clean load
        clear_logs();
        start_load(t0);
        for (int k = 0; k < 3; k++) send(8'h81 + 8'(k));
        i_rst   = 1'b1;
        s_valid = 1'b0;
        tick();
        chk("mid_rst_en",      {31'd0, c1_bias_en}, 32'd0);
        chk("mid_rst_data",    {24'd0, c1_bias_data}, 32'd0);
        chk("mid_rst_ready",   {31'd0, s_ready}, 32'd0);
        chk("mid_rst_busy",    {31'd0, o_busy}, 32'd0);
        chk("mid_rst_done",    {31'd0, o_done}, 32'd0);
        chk("mid_rst_loaded",  {31'd0, o_loaded}, 32'd0);
        chk("mid_rst_overrun", {31'd0, o_overrun}, 32'd0);
        chk("mid_rst_words", exp_q.size(), 0);
        i_rst = 1'b0;
        tick();
        clear_logs();
        start_load(t0);
        for (int k = 0; k < NW; k++) send(8'hA1 + 8'(k));
        s_valid = 1'b0;
        wait_idle(1);
        chk_en_seq(0, t0, NW, 0);
        chk("post_rst_loaded", {31'd0, o_loaded}, 32'd1);
        chk_buf(8'hA1);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
